// File: rtl/branch_predict_ctrl.sv
// Branch prediction / redirect controller for the 5-stage RV32I pipeline.
// 2-bit saturating BHT, registered mispredict redirect + flush, saturating statistics.
module branch_predict_ctrl #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  input  logic             if_is_branch,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [31:0]      ex_pc,
  input  logic             ex_pred_taken,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  logic [1:0]       bht [ENTRIES];
  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] widx;
  logic             res;
  logic             mis;
  logic             unused_pc_bits;

  assign ridx = if_pc[IDX_W+1:2];
  assign widx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  // Array read sees the pre-edge contents, so a same-cycle write returns the old value.
  assign if_pred_taken = if_is_branch & bht[ridx][1];

  // ex_valid gates everything first so X on other ex_* inputs cannot propagate.
  assign res = ex_valid & (ex_branch | ex_jump) & ~stall & (state == RUN);
  assign mis = res & (ex_jump ? ~ex_pred_taken : (ex_taken != ex_pred_taken));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= RUN;
      redirect       <= 1'b0;
      flush_ifid     <= 1'b0;
      flush_idex     <= 1'b0;
      redirect_pc    <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else begin
      case (state)
        RUN: begin
          if (mis) begin
            state       <= FLUSH;
            redirect    <= 1'b1;
            flush_ifid  <= 1'b1;
            flush_idex  <= 1'b1;
            redirect_pc <= (ex_jump | ex_taken) ? ex_target : ex_pc + 32'd4;
          end
        end
        FLUSH: begin
          state       <= RUN;
          redirect    <= 1'b0;
          flush_ifid  <= 1'b0;
          flush_idex  <= 1'b0;
          redirect_pc <= '0;
        end
        default: state <= RUN;
      endcase

      if (res && ex_branch) begin
        if (ex_taken) begin
          if (bht[widx] != 2'b11) bht[widx] <= bht[widx] + 2'd1;
        end else begin
          if (bht[widx] != 2'b00) bht[widx] <= bht[widx] - 2'd1;
        end
      end

      if (res && branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
      if (mis && mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: a driver computes expected redirects from a
// behavioural predictor model and queues them; a negedge monitor pops and compares.
module tb_branch_predict_ctrl;
  localparam int IDX_W = 4;
  // Narrow statistics counters so saturation is reachable in a short run.
  localparam int CNT_W = 8;
  localparam int NENT  = 1 << IDX_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      if_pc;
  logic             if_is_branch;
  logic             if_pred_taken;
  logic             ex_valid, ex_branch, ex_jump, ex_pred_taken, ex_taken, stall;
  logic [31:0]      ex_pc, ex_target;
  logic             redirect, flush_ifid, flush_idex;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispredict_cnt;

  branch_predict_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_is_branch(if_is_branch),
    .if_pred_taken(if_pred_taken), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
    .ex_target(ex_target), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    int          bcnt;
    int          mcnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   bht_m[NENT];
  int   bcnt_m, mcnt_m;
  bit   flush_m;
  bit   prev_red = 1'b0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void model_reset();
    foreach (bht_m[i]) bht_m[i] = 1;
    bcnt_m  = 0;
    mcnt_m  = 0;
    flush_m = 1'b0;
  endfunction

  function automatic int pidx(input logic [31:0] pc);
    return int'(pc[IDX_W+1:2]);
  endfunction

  // One clock: drive, check combinational prediction and counters, predict the next edge.
  task automatic step(input bit r, input bit v, input bit br, input bit jp,
                      input logic [31:0] pc, input bit pt, input bit tk,
                      input logic [31:0] tg, input bit st,
                      input logic [31:0] ipc, input bit ib);
    bit res, mis;
    int k;
    rst = r; ex_valid = v; stall = st; if_pc = ipc; if_is_branch = ib;
    if (v) begin
      ex_branch = br; ex_jump = jp; ex_pc = pc; ex_pred_taken = pt;
      ex_taken = tk; ex_target = tg;
    end else begin
      ex_branch = 'x; ex_jump = 'x; ex_pc = 'x; ex_pred_taken = 'x;
      ex_taken = 'x; ex_target = 'x;
    end
    #1;
    chk("if_pred_taken", if_pred_taken, (ib && bht_m[pidx(ipc)] >= 2) ? 1 : 0);
    chk("branch_cnt", branch_cnt, bcnt_m);
    chk("mispredict_cnt", mispredict_cnt, mcnt_m);
    if (!r) begin
      model_reset();
    end else begin
      res = v && (br || jp) && !st && !flush_m;
      mis = res && (jp ? !pt : (tk != pt));
      flush_m = mis;
      if (res && bcnt_m < CMAX) bcnt_m++;
      if (mis && mcnt_m < CMAX) mcnt_m++;
      if (res && br) begin
        k = pidx(pc);
        if (tk) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
        else    bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
      end
      if (mis) q.push_back('{cyc + 1, (jp || tk) ? tg : pc + 32'd4, bcnt_m, mcnt_m});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] ipc, input bit ib);
    step(1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, ipc, ib);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_redirect"}, redirect, 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
    chk({tag, "_flush_ifid"}, flush_ifid, 0);
    chk({tag, "_flush_idex"}, flush_idex, 0);
  endtask

  always @(negedge clk) begin
    if (redirect) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL unexpected_redirect: got redirect=1 pc=%0h expected no redirect (cycle %0d)",
                 redirect_pc, cyc);
      end else begin
        e = q.pop_front();
        chk("redirect_pc", redirect_pc, e.pc);
        chk("flush_ifid", flush_ifid, 1);
        chk("flush_idex", flush_idex, 1);
        chk("redirect_branch_cnt", branch_cnt, e.bcnt);
        chk("redirect_mispredict_cnt", mispredict_cnt, e.mcnt);
      end
      if (prev_red) begin
        checks++;
        errors++;
        $display("FAIL back_to_back_redirect: got 2 consecutive cycles expected 1 (cycle %0d)", cyc);
      end
    end else begin
      chk("idle_flush_ifid", flush_ifid, 0);
      chk("idle_flush_idex", flush_idex, 0);
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_redirect: got redirect=0 expected redirect to %0h (cycle %0d)",
                 e.pc, cyc);
      end
    end
    prev_red = redirect;
  end

  logic [31:0] r_pc, r_tg, r_ipc;
  bit          r_v, r_br, r_jp, r_pt, r_tk, r_st, r_rst, r_ib;
  int          kind;

  initial begin
    model_reset();
    r_st = 1'b0;
    step(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h100, 1);
    step(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h100, 1);
    check_cleared("reset");
    idle(32'h100, 1);

    // Mispredicted taken BEQ, then the trained entry predicts taken.
    step(1, 1, 1, 0, 32'h100, 0, 1, 32'h80, 0, 32'h100, 1);
    idle(32'h100, 1);
    idle(32'h100, 1);

    // Predicted-taken branch falls through, then a correct not-taken one.
    step(1, 1, 1, 0, 32'h200, 1, 0, 32'h999, 0, 32'h200, 1);
    idle(32'h200, 1);
    step(1, 1, 1, 0, 32'h200, 0, 0, 32'h999, 0, 32'h200, 1);
    idle(32'h200, 1);

    // Mispredict held under stall for three cycles.
    repeat (3) step(1, 1, 1, 0, 32'h140, 0, 1, 32'h40, 1, 32'h140, 1);
    step(1, 1, 1, 0, 32'h140, 0, 1, 32'h40, 0, 32'h140, 1);
    idle(32'h140, 1);
    idle(32'h140, 1);

    // Second mispredict presented in the FLUSH cycle is wrong-path.
    step(1, 1, 1, 0, 32'h180, 0, 1, 32'h10, 0, 32'h180, 1);
    step(1, 1, 1, 0, 32'h184, 0, 1, 32'h20, 0, 32'h184, 1);
    idle(32'h184, 1);

    // Fall-through address wraps; jump with pred=0 redirects to target.
    step(1, 1, 1, 0, 32'hFFFF_FFFC, 1, 0, 32'h4, 0, 32'h0, 0);
    idle(32'h0, 0);
    step(1, 1, 0, 1, 32'h300, 0, 1, 32'h1234, 0, 32'h300, 1);
    idle(32'h0, 0);
    step(1, 1, 0, 1, 32'h300, 1, 1, 32'h1234, 0, 32'h300, 1);
    idle(32'h0, 0);

    for (int n = 0; n < 2500; n++) begin
      if (!r_st) begin
        r_v  = ($urandom_range(0, 3) != 0);
        kind = int'($urandom_range(0, 3));
        r_br = (kind == 1 || kind == 2);
        r_jp = (kind == 3);
        r_pc = 32'h1000 + 32'($urandom_range(0, NENT - 1) * 4);
        r_tk = r_jp ? 1'b1 : bit'($urandom_range(0, 1));
        r_pt = ($urandom_range(0, 1) != 0) ? (bht_m[pidx(r_pc)] >= 2) : bit'($urandom_range(0, 1));
        r_tg = $urandom;
      end
      r_st  = ($urandom_range(0, 4) == 0);
      r_rst = ($urandom_range(0, 399) != 0);
      r_ipc = 32'h1000 + 32'($urandom_range(0, NENT - 1) * 4);
      r_ib  = bit'($urandom_range(0, 1));
      step(r_rst, r_v, r_br, r_jp, r_pc, r_pt, r_tk, r_tg, r_st, r_ipc, r_ib);
    end
    idle(32'h0, 0);
    idle(32'h0, 0);

    // Drive the statistics counters into saturation with back-to-back mispredicting jumps.
    repeat (2 * CMAX + 40) step(1, 1, 0, 1, 32'h400, 0, 1, 32'h500, 0, 32'h400, 1);
    idle(32'h0, 0);
    chk("mispredict_cnt_saturated", mispredict_cnt, CMAX);
    chk("branch_cnt_saturated", branch_cnt, CMAX);

    // Reset asserted during FLUSH: outputs clear and no redirect is re-issued.
    step(1, 1, 1, 0, 32'h500, 0, 1, 32'h600, 0, 32'h500, 1);
    step(0, 1, 1, 0, 32'h504, 0, 1, 32'h700, 0, 32'h500, 1);
    check_cleared("reset_in_flush");
    idle(32'h500, 1);
    idle(32'h500, 1);
    idle(32'h500, 1);

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
